bsg_link_upstream_arbiter: RTL and testbench

BSG_LINK_UPSTREAM_ARBITER -- requirements
Module: bsg_link_upstream_arbiter

---
 rtl/bsg_link_upstream_arbiter.sv | 106 ++++++++++
 tb/tb_bsg_link_upstream_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bsg_link_upstream_arbiter.sv
// bsg_link_upstream_arbiter: round-robin, credit-gated arbiter of NUM_REQ requesters onto one upstream link.
// Define BSG_LINK_ARB_BURST_EN to hold a grant for up to BURST_LEN transfers.
module bsg_link_upstream_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 64,
    parameter int MAX_CREDITS   = 32,
    parameter int TOKEN_CREDITS = 8,
    parameter int BURST_LEN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       link_valid_o,
    output logic [WIDTH-1:0]           link_data_o,
    input  logic                       link_ready_i,
    input  logic                       token_i,
    output logic [5:0]                 credits_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       overflow_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(MAX_CREDITS + TOKEN_CREDITS + 1) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state, w_state_next;
    logic [IW-1:0]   r_rr_ptr, r_grant, w_pick, w_grant_inc, w_rr_next, w_grant_next;
    logic [5:0]      r_credits, w_credits_next;
    logic            r_overflow;
    logic            w_has_credit, w_active, w_xfer, w_last_beat, w_ovf_hit;
    logic [SW-1:0]   w_sum;

    assign w_has_credit = r_credits != 6'd0;
    // Outputs are forced low while rst so a grant caught by reset never transfers.
    assign w_active     = !rst && r_state == GRANT && w_has_credit;
    assign link_valid_o = w_active && req_valid_i[r_grant];
    assign req_ready_o  = (w_active && link_ready_i) ? (NUM_REQ'(1) << r_grant) : '0;
    assign link_data_o  = req_data_i[r_grant*WIDTH +: WIDTH];
    assign w_xfer       = link_valid_o && link_ready_i;

    assign w_sum          = SW'(r_credits) + (token_i ? SW'(TOKEN_CREDITS) : '0) - SW'(w_xfer);
    assign w_ovf_hit      = w_sum > SW'(MAX_CREDITS);
    assign w_credits_next = w_ovf_hit ? 6'(MAX_CREDITS) : w_sum[5:0];

    assign w_grant_inc  = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign credits_o    = r_credits;
    assign grant_id_o   = r_grant;
    assign overflow_o   = r_overflow;

    // Descending scan so the valid requester closest at/after rr_ptr wins.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid_i[(int'(r_rr_ptr) + i) % NUM_REQ])
                w_pick = IW'((int'(r_rr_ptr) + i) % NUM_REQ);
    end

`ifdef BSG_LINK_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] r_beats;

    assign w_last_beat = w_xfer && r_beats == BW'(BURST_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE)
            r_beats <= '0;
        else if (w_xfer)
            r_beats <= r_beats + 1'b1;
    end
`else
    assign w_last_beat = w_xfer;
`endif

    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr_ptr;
        w_grant_next = r_grant;
        if (r_state == IDLE) begin
            if (|req_valid_i && w_has_credit) begin
                w_state_next = GRANT;
                w_grant_next = w_pick;
            end
        end else if (w_last_beat || !req_valid_i[r_grant] || w_credits_next == 6'd0) begin
            w_state_next = IDLE;
            w_rr_next    = w_grant_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_credits  <= 6'(MAX_CREDITS);
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_next;
            r_grant    <= w_grant_next;
            r_credits  <= w_credits_next;
            r_overflow <= r_overflow | w_ovf_hit;
        end
    end
endmodule

// File: tb/tb_bsg_link_upstream_arbiter.sv
// tb_bsg_link_upstream_arbiter: random stimulus against a transaction-level model; transfers checked through a scoreboard queue.
module tb_bsg_link_upstream_arbiter;
    localparam int N = 4, W = 64, MAXC = 32, TOK = 8, NCYC = 2000;
`ifdef BSG_LINK_ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    logic             clk = 0, rst = 1;
    logic [N-1:0]     req_valid_i = '0;
    logic [N*W-1:0]   req_data_i = '0;
    logic [N-1:0]     req_ready_o;
    logic             link_valid_o;
    logic [W-1:0]     link_data_o;
    logic             link_ready_i = 0;
    logic             token_i = 0;
    logic [5:0]       credits_o;
    logic [1:0]       grant_id_o;
    logic             overflow_o;

    always #5 clk = ~clk;

    bsg_link_upstream_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_CREDITS(MAXC), .TOKEN_CREDITS(TOK), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .link_valid_o(link_valid_o), .link_data_o(link_data_o),
        .link_ready_i(link_ready_i), .token_i(token_i), .credits_o(credits_o),
        .grant_id_o(grant_id_o), .overflow_o(overflow_o)
    );

    typedef struct { int id; logic [W-1:0] data; } xfer_t;
    xfer_t sb[$];
    int tests = 0, fails = 0;

    // Model: whether a grant is held, who holds it, beats used, credits, search start.
    bit m_busy, m_ovf, m_known;
    int m_gid, m_rr, m_cred, m_beats;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (req_valid_i[(m_rr + k) % N]) return (m_rr + k) % N;
        return m_rr;
    endfunction

    initial begin
        bit e_lv, x;
        logic [N-1:0] e_rdy;
        int raw;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst = (c < 2) || (c >= 1200 && $urandom_range(0, 149) == 0);
            if (c < 40) begin
                req_valid_i = '1;
                link_ready_i = 1;
                token_i = 0;
            end else begin
                for (int i = 0; i < N; i++) req_valid_i[i] = $urandom_range(0, 3) != 0;
                link_ready_i = $urandom_range(0, 4) != 0;
                if (c < 400) token_i = $urandom_range(0, 29) == 0;
                else if (c < 800) token_i = 0;
                else if (c < 1200) token_i = $urandom_range(0, 1) == 0;
                else token_i = $urandom_range(0, 9) == 0;
            end
            for (int i = 0; i < N; i++) req_data_i[i*W +: W] = {$urandom, $urandom};
            #1;
            e_lv = !rst && m_busy && m_cred > 0 && req_valid_i[m_gid];
            e_rdy = (!rst && m_busy && m_cred > 0 && link_ready_i) ? N'(1) << m_gid : '0;
            x = e_lv && link_ready_i;
            check("link_valid", 64'(link_valid_o), 64'(e_lv));
            check("req_ready", 64'(req_ready_o), 64'(e_rdy));
            if (m_known) begin
                check("credits", 64'(credits_o), 64'(m_cred));
                check("grant_id", 64'(grant_id_o), 64'(m_gid));
                check("overflow", 64'(overflow_o), 64'(m_ovf));
            end
            if (x) sb.push_back('{m_gid, req_data_i[m_gid*W +: W]});
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_rr = 0; m_gid = 0; m_cred = MAXC; m_ovf = 0; m_beats = 0; m_known = 1;
            end else begin
                raw = m_cred + (token_i ? TOK : 0) - (x ? 1 : 0);
                if (raw > MAXC) begin raw = MAXC; m_ovf = 1; end
                if (!m_busy) begin
                    if (req_valid_i != 0 && m_cred != 0) begin
                        m_busy = 1; m_gid = pick(); m_beats = 0;
                    end
                end else begin
                    m_beats += x ? 1 : 0;
                    if ((x && m_beats == BL) || !req_valid_i[m_gid] || raw == 0) begin
                        m_busy = 0; m_rr = (m_gid + 1) % N;
                    end
                end
                m_cred = raw;
            end
        end
        req_valid_i = '0;
        rst = 0;
        @(negedge clk);
        #3;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial forever begin
        xfer_t e;
        @(negedge clk);
        #2;
        if (link_valid_o && link_ready_i) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL xfer: unexpected transfer from %0d data %0h", grant_id_o, link_data_o);
            end else begin
                e = sb.pop_front();
                if (int'(grant_id_o) != e.id || link_data_o !== e.data) begin
                    fails++;
                    $display("FAIL xfer: got id %0d data %0h expected id %0d data %0h", grant_id_o, link_data_o, e.id, e.data);
                end
            end
        end
    end
endmodule
